// File: rtl/pfd_digital_loop_filter_if.sv
// pfd_digital_loop_filter_if: PFD pulse inputs and DCO control outputs of the loop filter.
interface pfd_digital_loop_filter_if #(
    parameter int CW = 10,
    parameter int WW = 8
);
    logic          up;
    logic          dn;
    logic [CW-1:0] ctrl;
    logic          ctrl_valid;
    logic [WW-1:0] evt_width;
    logic          lock;

    modport master (output up, dn, input ctrl, ctrl_valid, evt_width, lock);
    modport slave  (input up, dn, output ctrl, ctrl_valid, evt_width, lock);
endinterface

// File: rtl/pfd_digital_loop_filter.sv
// pfd_digital_loop_filter: measures PFD up/dn events and applies a saturated P+I update to the DCO code.
// Define LOCK_DETECT_EN to build the lock counter; otherwise lock is tied low.
module pfd_digital_loop_filter #(
    parameter int CW        = 10,
    parameter int WW        = 8,
    parameter int IW        = 16,
    parameter int KP_SHIFT  = 2,
    parameter int KI_SHIFT  = 2,
    parameter int CTRL_INIT = 512,
    parameter int LOCK_TOL  = 1,
    parameter int LOCK_CNT  = 4
) (
    input logic                      ck,
    input logic                      rst,
    pfd_digital_loop_filter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEAS = 2'd1;
    localparam logic [1:0] UPD  = 2'd2;
    localparam logic signed [WW-1:0] ONE  = 1;
    localparam logic signed [WW-1:0] AMAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] AMIN = -AMAX;
    localparam logic signed [IW-1:0] IMAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] IMIN = {1'b1, {(IW-1){1'b0}}};
    localparam logic signed [31:0] CINIT = CTRL_INIT;
    localparam logic signed [31:0] CMAX  = (1 << CW) - 1;

    logic [1:0] up_q, dn_q, state, state_nxt;
    logic up_s, dn_s, active, inc, dec, ctrl_valid;
    logic signed [WW-1:0] acc, acc_start, acc_step, ew;
    logic signed [IW:0] isum;
    logic signed [IW-1:0] integ, integ_nxt;
    logic signed [31:0] sum;
    logic [CW-1:0] ctrl, ctrl_nxt;

    always_comb begin
        up_s      = up_q[1];
        dn_s      = dn_q[1];
        active    = up_s | dn_s;
        inc       = up_s & !dn_s;
        dec       = dn_s & !up_s;
        acc_start = inc ? ONE : dec ? -ONE : '0;
        acc_step  = (inc && acc != AMAX) ? acc + ONE : (dec && acc != AMIN) ? acc - ONE : acc;
        state_nxt = (state == MEAS) ? (active ? MEAS : UPD) : (active ? MEAS : IDLE);
        isum      = {integ[IW-1], integ} + {{(IW+1-WW){ew[WW-1]}}, ew};
        integ_nxt = (isum[IW] != isum[IW-1]) ? (isum[IW] ? IMIN : IMAX) : isum[IW-1:0];
        // Sum at 32 bits so the proportional and integral terms cannot overflow before clamping
        sum       = CINIT + {{(32-IW){integ_nxt[IW-1]}}, integ_nxt >>> KI_SHIFT}
                  + ({{(32-WW){ew[WW-1]}}, ew} <<< KP_SHIFT);
        ctrl_nxt  = (sum < 0) ? '0 : (sum > CMAX) ? '1 : sum[CW-1:0];
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            up_q       <= '0;
            dn_q       <= '0;
            state      <= IDLE;
            acc        <= '0;
            ew         <= '0;
            integ      <= '0;
            ctrl       <= CW'(CTRL_INIT);
            ctrl_valid <= 1'b0;
        end else begin
            up_q       <= {up_q[0], bus.up};
            dn_q       <= {dn_q[0], bus.dn};
            state      <= state_nxt;
            acc        <= (state == MEAS) ? acc_step : acc_start;
            ctrl_valid <= state == UPD;
            if (state == MEAS && !active) ew <= acc;
            if (state == UPD) begin
                integ <= integ_nxt;
                ctrl  <= ctrl_nxt;
            end
        end
    end

`ifdef LOCK_DETECT_EN
    localparam int NW = $clog2(LOCK_CNT + 1);
    localparam logic [NW-1:0] NMAX = NW'(LOCK_CNT);
    localparam logic signed [WW-1:0] TOL = WW'(LOCK_TOL);

    logic [NW-1:0] lcnt, lcnt_nxt;
    logic in_tol, lock;

    always_comb begin
        in_tol   = (ew <= TOL) && (ew >= -TOL);
        lcnt_nxt = !in_tol ? '0 : (lcnt == NMAX) ? lcnt : lcnt + NW'(1);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            lcnt <= '0;
            lock <= 1'b0;
        end else if (state == UPD) begin
            lcnt <= lcnt_nxt;
            lock <= lcnt_nxt == NMAX;
        end
    end

    assign bus.lock = lock;
`else
    assign bus.lock = 1'b0;
`endif

    assign bus.ctrl       = ctrl;
    assign bus.ctrl_valid = ctrl_valid;
    assign bus.evt_width  = ew;
endmodule
